// File: rtl/lms_mac_engine.sv
// Sequential LMS multiply-accumulate engine: sample delay line, weight file, one tap per cycle.
// Define LMS_MAC_SAT_EN to saturate each accumulate step to the 64-bit signed bounds.
module lms_mac_engine #(
    parameter int DATA_W = 32,
    parameter int TAPS   = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              w_wr_en,
    input  logic [IDX_W-1:0]  w_wr_addr,
    input  logic [DATA_W-1:0] w_wr_data,
    input  logic              ovr_clr,
    output logic [63:0]       acc_out,
    output logic              acc_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] x_line [TAPS];
    logic signed [DATA_W-1:0] w_mem  [TAPS];
    logic signed [63:0]       acc;
    logic signed [63:0]       prod;
    logic signed [63:0]       acc_nxt;
    logic [IDX_W-1:0]         k;
    logic                     accept;
    logic                     drop;

    assign accept = (state == IDLE) && sample_valid;
    assign drop   = (state != IDLE) && sample_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sample_valid) state_nxt = MAC;
            MAC:  if (k == LAST_TAP) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MAC) || (state == DONE);
    end

    // Operands are sign-extended to 64 bits first, so the 64-bit product equals the full-precision one.
    always_comb begin
        prod = 64'(w_mem[k]) * 64'(x_line[k]);
    end

`ifdef LMS_MAC_SAT_EN
    logic signed [63:0] sum;

    always_comb begin
        sum     = acc + prod;
        acc_nxt = sum;
        if ((acc[63] == prod[63]) && (sum[63] != acc[63])) begin
            acc_nxt = acc[63] ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF;
        end
    end
`else
    always_comb begin
        acc_nxt = acc + prod;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
            end
        end else if (accept) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                x_line[i] <= x_line[i-1];
            end
            x_line[0] <= sample_in;
        end
    end

    // Writes land at the edge, so a MAC step reading the same index this cycle still sees the old weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                w_mem[i] <= '0;
            end
        end else if (w_wr_en && (int'(w_wr_addr) < TAPS)) begin
            w_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            k         <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= (state == DONE);
            if (accept) begin
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
            end
            if (state == DONE) begin
                acc_out <= acc;
            end
        end
    end

    // A dropped sample sets the flag even when a clear arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
